tedv3_sysid_checker: RTL and testbench

Boot-time sequencer for the Avalon system-ID slave. On request it reads the ID word (address 0) and the build-timestamp word (address 1), compares both against compile-time expected values, retries a bounded number of times on mismatch, and reports pass/fail. It sits between the system-ID slave and the board bring-up logic, gating encryption-engine enable until the hardware build is confirmed.

---
 rtl/tedv3_sysid_checker.sv | 158 +++++++++++++++
 tb/tb_tedv3_sysid_checker.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/tedv3_sysid_checker.sv
// Boot-time system-ID checker: reads ID (addr 0) and build timestamp (addr 1), compares, retries, reports.
// Optional SYSID_AUTOSTART_EN: launches one check on the first cycle after reset release.
module tedv3_sysid_checker #(
   parameter logic [31:0] EXPECTED_ID  = 32'h12345678,
   parameter logic [31:0] EXPECTED_TS  = 32'h5519CDCD,
   parameter int unsigned READ_LATENCY = 1,
   parameter int unsigned MAX_RETRY    = 3
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        start,
   output logic        sysid_address,
   output logic        sysid_read,
   input  logic [31:0] sysid_readdata,
   output logic        busy,
   output logic        done,
   output logic        pass,
   output logic        fail,
   output logic        id_ok,
   output logic        ts_ok,
   output logic [31:0] captured_id,
   output logic [31:0] captured_ts,
   output logic [3:0]  retry_count
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      RD_ID  = 3'd1,
      RD_TS  = 3'd2,
      CHECK  = 3'd3,
      REPORT = 3'd4
   } state_t;

   localparam logic [3:0] WAIT_LAST = 4'(READ_LATENCY - 1);
   localparam logic [3:0] RETRY_MAX = 4'(MAX_RETRY);

   state_t      state_q, state_d;
   logic [3:0]  wait_q, wait_d;
   logic [3:0]  retry_q, retry_d;
   logic [31:0] cap_id_q, cap_id_d;
   logic [31:0] cap_ts_q, cap_ts_d;
   logic        pass_q, pass_d;
   logic        fail_q, fail_d;
   logic        id_ok_q, id_ok_d;
   logic        ts_ok_q, ts_ok_d;
   logic        go;

`ifdef SYSID_AUTOSTART_EN
   // Armed by reset, consumed on the first cycle after release.
   logic armed_q;
   logic armed_d;
   assign armed_d = 1'b0;
   always_ff @(posedge clock or posedge reset) begin
      if (reset) armed_q <= 1'b1;
      else       armed_q <= armed_d;
   end
   assign go = start | armed_q;
`else
   assign go = start;
`endif

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         wait_q   <= 4'd0;
         retry_q  <= 4'd0;
         cap_id_q <= 32'd0;
         cap_ts_q <= 32'd0;
         pass_q   <= 1'b0;
         fail_q   <= 1'b0;
         id_ok_q  <= 1'b0;
         ts_ok_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         wait_q   <= wait_d;
         retry_q  <= retry_d;
         cap_id_q <= cap_id_d;
         cap_ts_q <= cap_ts_d;
         pass_q   <= pass_d;
         fail_q   <= fail_d;
         id_ok_q  <= id_ok_d;
         ts_ok_q  <= ts_ok_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      wait_d   = wait_q;
      retry_d  = retry_q;
      cap_id_d = cap_id_q;
      cap_ts_d = cap_ts_q;
      pass_d   = pass_q;
      fail_d   = fail_q;
      id_ok_d  = id_ok_q;
      ts_ok_d  = ts_ok_q;
      case (state_q)
         IDLE: begin
            if (go) begin
               state_d = RD_ID;
               wait_d  = 4'd0;
               retry_d = 4'd0;
               pass_d  = 1'b0;
               fail_d  = 1'b0;
               id_ok_d = 1'b0;
               ts_ok_d = 1'b0;
            end
         end
         RD_ID: begin
            if (wait_q == WAIT_LAST) begin
               cap_id_d = sysid_readdata;
               wait_d   = 4'd0;
               state_d  = RD_TS;
            end else begin
               wait_d = wait_q + 4'd1;
            end
         end
         RD_TS: begin
            if (wait_q == WAIT_LAST) begin
               cap_ts_d = sysid_readdata;
               wait_d   = 4'd0;
               state_d  = CHECK;
            end else begin
               wait_d = wait_q + 4'd1;
            end
         end
         CHECK: begin
            id_ok_d = (cap_id_q == EXPECTED_ID);
            ts_ok_d = (cap_ts_q == EXPECTED_TS);
            if ((cap_id_q == EXPECTED_ID) && (cap_ts_q == EXPECTED_TS)) begin
               pass_d  = 1'b1;
               state_d = REPORT;
            end else if (retry_q < RETRY_MAX) begin
               retry_d = retry_q + 4'd1;
               state_d = RD_ID;
            end else begin
               fail_d  = 1'b1;
               state_d = REPORT;
            end
         end
         REPORT: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Bus outputs decode straight from state so the address only moves on transitions.
   assign sysid_read    = (state_q == RD_ID) || (state_q == RD_TS);
   assign sysid_address = (state_q == RD_TS);
   assign busy          = (state_q != IDLE);
   assign done          = (state_q == REPORT);
   assign pass          = pass_q;
   assign fail          = fail_q;
   assign id_ok         = id_ok_q;
   assign ts_ok         = ts_ok_q;
   assign captured_id   = cap_id_q;
   assign captured_ts   = cap_ts_q;
   assign retry_count   = retry_q;

endmodule

// File: tb/tb_tedv3_sysid_checker.sv
// Directed bench for tedv3_sysid_checker: one instance at READ_LATENCY=1, one at READ_LATENCY=3.
module tb_tedv3_sysid_checker;

   localparam logic [31:0] EXP_ID = 32'h12345678;
   localparam logic [31:0] EXP_TS = 32'h5519CDCD;

   // clock / reset
   logic clock = 1'b0;
   logic reset;
   always #5 clock = ~clock;

   logic start, start3;

   logic        addr1, rd1, busy1, done1, pass1, fail1, idok1, tsok1;
   logic [31:0] rdata1, capid1, capts1;
   logic [3:0]  rc1;
   logic        addr3, rd3, busy3, done3, pass3, fail3, idok3, tsok3;
   logic [31:0] rdata3, capid3, capts3;
   logic [3:0]  rc3;

   tedv3_sysid_checker #(.READ_LATENCY(1), .MAX_RETRY(3)) dut (
      .clock(clock), .reset(reset), .start(start),
      .sysid_address(addr1), .sysid_read(rd1), .sysid_readdata(rdata1),
      .busy(busy1), .done(done1), .pass(pass1), .fail(fail1),
      .id_ok(idok1), .ts_ok(tsok1), .captured_id(capid1), .captured_ts(capts1),
      .retry_count(rc1)
   );

   tedv3_sysid_checker #(.READ_LATENCY(3), .MAX_RETRY(3)) dut3 (
      .clock(clock), .reset(reset), .start(start3),
      .sysid_address(addr3), .sysid_read(rd3), .sysid_readdata(rdata3),
      .busy(busy3), .done(done3), .pass(pass3), .fail(fail3),
      .id_ok(idok3), .ts_ok(tsok3), .captured_id(capid3), .captured_ts(capts3),
      .retry_count(rc3)
   );

   // slave models
   logic [31:0] id_val, ts_val;
   int          id_reads = 0;
   int          ts_reads = 0;
   int          ts_bad_until = 0;

   always @(posedge clock) begin
      if (rd1 && !addr1) id_reads <= id_reads + 1;
      if (rd1 && addr1)  ts_reads <= ts_reads + 1;
   end

   always_comb begin
      rdata1 = id_val;
      if (addr1) rdata1 = (ts_reads < ts_bad_until) ? 32'h0 : ts_val;
   end

   always_comb begin
      rdata3 = addr3 ? EXP_TS : EXP_ID;
   end

   // scoreboard
   int n_checks = 0;
   int n_fail   = 0;
   logic [31:0] exp_q[$];

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // driver: pulse start on dut, wait (bounded) for done, check latency against the queue
   task automatic run1(input string tag, output int nid);
      int lat;
      int id0;
      logic [31:0] exp_lat;
      id0 = id_reads;
      start = 1'b1;
      @(posedge clock); #1;
      start = 1'b0;
      lat = 1;
      while (!done1 && lat < 100) begin
         @(posedge clock); #1;
         lat++;
      end
      exp_lat = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hFFFF_FFFF;
      check_eq({tag, "_latency"}, 32'(lat), exp_lat);
      nid = id_reads - id0;
   endtask

   task automatic count_trailing_done(input string tag);
      int nd;
      nd = 0;
      repeat (6) begin
         @(posedge clock); #1;
         nd += int'(done1);
      end
      check_eq({tag, "_extra_done"}, 32'(nd), 32'd0);
   endtask

   int nid;
   logic [9:0] rdp, ap, dp;
   int extra3;

   initial begin
      reset  = 1'b1;
      start  = 1'b0;
      start3 = 1'b0;
      id_val = EXP_ID;
      ts_val = EXP_TS;
      repeat (2) @(posedge clock);
      #1;
      check_eq("rst_busy",  {31'd0, busy1}, 32'd0);
      check_eq("rst_pass",  {31'd0, pass1}, 32'd0);
      check_eq("rst_fail",  {31'd0, fail1}, 32'd0);
      check_eq("rst_read",  {31'd0, rd1},   32'd0);
      check_eq("rst_capid", capid1,         32'd0);
      check_eq("rst_retry", {28'd0, rc1},   32'd0);
      reset = 1'b0;
      @(posedge clock); #1;

      // good first attempt
      exp_q.push_back(32'd4);
      run1("good", nid);
      check_eq("good_pass",  {31'd0, pass1}, 32'd1);
      check_eq("good_fail",  {31'd0, fail1}, 32'd0);
      check_eq("good_retry", {28'd0, rc1},   32'd0);
      check_eq("good_capid", capid1,         EXP_ID);
      check_eq("good_capts", capts1,         EXP_TS);
      check_eq("good_okbits", {30'd0, idok1, tsok1}, 32'd3);
      count_trailing_done("good");

      // ID always wrong: 4 attempts, fail
      id_val = 32'hDEADBEEF;
      exp_q.push_back(32'd13);
      run1("badid", nid);
      check_eq("badid_reads", 32'(nid),       32'd4);
      check_eq("badid_fail",  {31'd0, fail1}, 32'd1);
      check_eq("badid_pass",  {31'd0, pass1}, 32'd0);
      check_eq("badid_idok",  {31'd0, idok1}, 32'd0);
      check_eq("badid_tsok",  {31'd0, tsok1}, 32'd1);
      check_eq("badid_retry", {28'd0, rc1},   32'd3);
      check_eq("badid_capid", capid1,         32'hDEADBEEF);
      count_trailing_done("badid");

      // first timestamp read is zero, retry recovers
      id_val = EXP_ID;
      ts_bad_until = ts_reads + 1;
      exp_q.push_back(32'd7);
      run1("ts0", nid);
      check_eq("ts0_pass",  {31'd0, pass1}, 32'd1);
      check_eq("ts0_fail",  {31'd0, fail1}, 32'd0);
      check_eq("ts0_retry", {28'd0, rc1},   32'd1);
      check_eq("ts0_capts", capts1,         EXP_TS);

      // READ_LATENCY=3 address sequence; start during busy ignored
      @(posedge clock); #1;
      start3 = 1'b1;
      @(posedge clock); #1;
      start3 = 1'b0;
      for (int c = 1; c <= 10; c++) begin
         rdp[c-1] = rd3;
         ap[c-1]  = addr3;
         dp[c-1]  = done3;
         if (c == 3) start3 = 1'b1;
         if (c == 4) start3 = 1'b0;
         if (c < 10) begin
            @(posedge clock); #1;
         end
      end
      extra3 = 0;
      repeat (6) begin
         @(posedge clock); #1;
         extra3 += int'(done3);
      end
      check_eq("lat3_read", {22'd0, rdp}, {22'd0, 10'b0000111111});
      check_eq("lat3_addr", {22'd0, ap},  {22'd0, 10'b0000111000});
      check_eq("lat3_done", {22'd0, dp},  {22'd0, 10'b0010000000});
      check_eq("lat3_extra_done", 32'(extra3), 32'd0);
      check_eq("lat3_pass", {31'd0, pass3}, 32'd1);
      check_eq("lat3_capts", capts3, EXP_TS);

      // reset while in RD_TS
      start = 1'b1;
      @(posedge clock); #1;
      start = 1'b0;
      @(posedge clock); #1;
      check_eq("mid_in_rdts", {31'd0, addr1}, 32'd1);
      check_eq("mid_capid_pre", capid1, EXP_ID);
      reset = 1'b1;
      #1;
      check_eq("mid_busy",  {31'd0, busy1}, 32'd0);
      check_eq("mid_read",  {31'd0, rd1},   32'd0);
      check_eq("mid_addr",  {31'd0, addr1}, 32'd0);
      check_eq("mid_done",  {31'd0, done1}, 32'd0);
      check_eq("mid_capid", capid1,         32'd0);
      @(posedge clock); #1;
      check_eq("mid_done_hold", {31'd0, done1}, 32'd0);
      reset = 1'b0;
      @(posedge clock); #1;
      exp_q.push_back(32'd4);
      run1("after_rst", nid);
      check_eq("after_rst_pass", {31'd0, pass1}, 32'd1);
      check_eq("after_rst_fail", {31'd0, fail1}, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
